// File: rtl/ppm_dec_pkg.sv
// Shared types and constants for the PPM symbol decoder.
// Error codes double as the sym_err port encoding.
package ppm_dec_pkg;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_EMPTY = 2'b01,
    ERR_MULTI = 2'b10
  } ppm_err_t;

  localparam int ERRCNT_W = 8;

  function automatic ppm_err_t classify(input logic found, input logic multi);
    if (multi)       return ERR_MULTI;
    else if (!found) return ERR_EMPTY;
    else             return ERR_OK;
  endfunction

endpackage

// File: rtl/ppm_slot_timer.sv
// Symbol timer: divides the active frame into NSLOT slots of SLOT_TICKS ticks
// and flags the sampling tick and the final tick of each symbol.
module ppm_slot_timer #(
  parameter int SYM_BITS    = 2,
  parameter int SLOT_TICKS  = 2,
  parameter int SAMPLE_TICK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                clear,
  output logic                sample_en,
  output logic                sym_end,
  output logic [SYM_BITS-1:0] slot_idx
);

  localparam int NSLOT  = 1 << SYM_BITS;
  localparam int TICK_W = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;

  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SYM_BITS-1:0] slot_cnt_q, slot_cnt_d;
  logic                tick_last, slot_last;

  assign tick_last = (tick_cnt_q == TICK_W'(SLOT_TICKS - 1));
  assign slot_last = (slot_cnt_q == SYM_BITS'(NSLOT - 1));

  assign sample_en = tick && (tick_cnt_q == TICK_W'(SAMPLE_TICK));
  assign sym_end   = tick && tick_last && slot_last;
  assign slot_idx  = slot_cnt_q;

  // NOTE: defaults first so every path assigns both next-state values; no latches.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    slot_cnt_d = slot_cnt_q;
    if (clear) begin
      tick_cnt_d = '0;
      slot_cnt_d = '0;
    end else if (tick) begin
      if (tick_last) begin
        tick_cnt_d = '0;
        slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments for all registered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      slot_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      slot_cnt_q <= slot_cnt_d;
    end
  end

endmodule

// File: rtl/ppm_symbol_decoder.sv
// PPM symbol decoder: samples an active-low pulse line once per slot and emits
// one decoded symbol plus error code per symbol. PPMDEC_ERRCNT_EN adds err_cnt.
module ppm_symbol_decoder
  import ppm_dec_pkg::*;
#(
  parameter int SYM_BITS    = 2,
  parameter int SLOT_TICKS  = 2,
  parameter int SAMPLE_TICK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk16,
  input  logic                state_in,
  input  logic                Din,
  output logic [SYM_BITS-1:0] sym_data,
  output logic [1:0]          sym_err,
  output logic                sym_valid,
  input  logic                sym_ready,
  output logic                ovf
`ifdef PPMDEC_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  logic                din_q;
  logic                tick, sample_en, sym_end;
  logic [SYM_BITS-1:0] slot_idx;

  logic                found_q, found_d;
  logic                multi_q, multi_d;
  logic [SYM_BITS-1:0] pos_q, pos_d;

  logic                hit, found_now, multi_now;
  logic [SYM_BITS-1:0] pos_now;
  ppm_err_t            res_err;

  logic [SYM_BITS-1:0] sym_data_q, sym_data_d;
  ppm_err_t            sym_err_q, sym_err_d;
  logic                sym_valid_q, sym_valid_d;
  logic                ovf_q, ovf_d;
  logic                load, drop, transfer;

  assign tick = clk16 && state_in;

  ppm_slot_timer #(
    .SYM_BITS   (SYM_BITS),
    .SLOT_TICKS (SLOT_TICKS),
    .SAMPLE_TICK(SAMPLE_TICK)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .clear    (!state_in),
    .sample_en(sample_en),
    .sym_end  (sym_end),
    .slot_idx (slot_idx)
  );

  // The result folds in a sample taken on the commit tick itself.
  assign hit       = sample_en && din_q;
  assign found_now = found_q || hit;
  assign multi_now = multi_q || (hit && found_q);
  assign pos_now   = found_q ? pos_q : (hit ? slot_idx : '0);
  assign res_err   = classify(found_now, multi_now);

  assign transfer = sym_valid_q && sym_ready;
  assign load     = sym_end && (!sym_valid_q || sym_ready);
  assign drop     = sym_end && sym_valid_q && !sym_ready;

  always_comb begin
    found_d     = found_now;
    multi_d     = multi_now;
    pos_d       = pos_now;
    sym_data_d  = sym_data_q;
    sym_err_d   = sym_err_q;
    sym_valid_d = sym_valid_q;
    ovf_d       = ovf_q;

    if (!state_in || sym_end) begin
      found_d = 1'b0;
      multi_d = 1'b0;
      pos_d   = '0;
    end

    if (load) begin
      sym_data_d  = pos_now;
      sym_err_d   = res_err;
      sym_valid_d = 1'b1;
    end else if (transfer) begin
      sym_valid_d = 1'b0;
    end

    if (!state_in)  ovf_d = 1'b0;
    else if (drop)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q       <= 1'b0;
      found_q     <= 1'b0;
      multi_q     <= 1'b0;
      pos_q       <= '0;
      sym_data_q  <= '0;
      sym_err_q   <= ERR_OK;
      sym_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      din_q       <= !Din;
      found_q     <= found_d;
      multi_q     <= multi_d;
      pos_q       <= pos_d;
      sym_data_q  <= sym_data_d;
      sym_err_q   <= sym_err_d;
      sym_valid_q <= sym_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign sym_data  = sym_data_q;
  assign sym_err   = sym_err_q;
  assign sym_valid = sym_valid_q;
  assign ovf       = ovf_q;

`ifdef PPMDEC_ERRCNT_EN
  // Dropped commits are still counted: the error happened on the line.
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (sym_end && (res_err != ERR_OK) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
`endif

endmodule

// File: tb/tb_ppm_symbol_decoder.sv
// Scoreboard bench for ppm_symbol_decoder: directed test-plan symbols followed by
// randomized line/tick/ready traffic against a slot-level reference model.
module tb_ppm_symbol_decoder;
  import ppm_dec_pkg::*;

  localparam int SYM_BITS    = 2;
  localparam int SLOT_TICKS  = 2;
  localparam int SAMPLE_TICK = 1;
  localparam int NSLOT       = 1 << SYM_BITS;
  localparam int TPS         = NSLOT * SLOT_TICKS;

  logic                clk = 1'b0;
  logic                rst_n, clk16, state_in, Din, sym_ready;
  logic [SYM_BITS-1:0] sym_data;
  logic [1:0]          sym_err;
  logic                sym_valid, ovf;
`ifdef PPMDEC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt;
`endif

  ppm_symbol_decoder #(
    .SYM_BITS   (SYM_BITS),
    .SLOT_TICKS (SLOT_TICKS),
    .SAMPLE_TICK(SAMPLE_TICK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk16    (clk16),
    .state_in (state_in),
    .Din      (Din),
    .sym_data (sym_data),
    .sym_err  (sym_err),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .ovf      (ovf)
`ifdef PPMDEC_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int err;
  } res_t;

  res_t exp_q[$];
  res_t mon_r;
  int   checks = 0;
  int   errors = 0;

  // Reference model: a position within the symbol, the set of slots that saw
  // a pulse, and a one-entry output buffer.
  int             k_m      = 0;
  bit [NSLOT-1:0] hits_m   = '0;
  bit             prev_din = 1'b1;
  bit             occ_m    = 1'b0;
  bit             ovf_m    = 1'b0;
  int             errcnt_m = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    k_m      = 0;
    hits_m   = '0;
    prev_din = 1'b1;
    occ_m    = 1'b0;
    ovf_m    = 1'b0;
    errcnt_m = 0;
    exp_q.delete();
  endtask

  // One clk cycle of stimulus, followed by the model's view of that edge.
  task automatic cycle(input bit c16, input bit st, input bit d, input bit rdy);
    bit   commit;
    int   n;
    res_t r;
    clk16     = c16;
    state_in  = st;
    Din       = d;
    sym_ready = rdy;
    @(posedge clk);
    commit = 1'b0;
    if (!st) begin
      k_m    = 0;
      hits_m = '0;
      ovf_m  = 1'b0;
    end else if (c16) begin
      if ((k_m % SLOT_TICKS) == SAMPLE_TICK && !prev_din)
        hits_m[k_m / SLOT_TICKS] = 1'b1;
      if (k_m == TPS - 1) begin
        commit = 1'b1;
        k_m    = 0;
      end else begin
        k_m++;
      end
    end
    prev_din = d;
    if (commit) begin
      n      = $countones(hits_m);
      r.data = 0;
      for (int s = NSLOT - 1; s >= 0; s--)
        if (hits_m[s]) r.data = s;
      r.err  = (n == 0) ? 1 : (n == 1) ? 0 : 2;
      hits_m = '0;
      if (r.err != 0 && errcnt_m < 255) errcnt_m++;
      if (!occ_m || rdy) begin
        exp_q.push_back(r);
        occ_m = 1'b1;
      end else begin
        ovf_m = 1'b1;
      end
    end else if (occ_m && rdy) begin
      occ_m = 1'b0;
    end
    #1;
  endtask

  // Drive nticks ticks of a symbol; a set bit in pulses puts a pulse in that slot.
  task automatic run_symbol(input bit [NSLOT-1:0] pulses, input bit rdy, input int nticks);
    for (int t = 0; t < nticks; t++) begin
      cycle(1'b0, 1'b1,
            ((t % SLOT_TICKS) == SAMPLE_TICK && pulses[t / SLOT_TICKS]) ? 1'b0 : 1'b1, rdy);
      cycle(1'b1, 1'b1, 1'b1, rdy);
    end
  endtask

  task automatic align();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_data", sym_data, 0);
    check("rst_sym_err", sym_err, 0);
    check("rst_ovf", ovf, 0);
`ifdef PPMDEC_ERRCNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: state checks every cycle, result pops on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      check("sym_valid", sym_valid, occ_m);
      check("ovf", ovf, ovf_m);
`ifdef PPMDEC_ERRCNT_EN
      check("err_cnt", err_cnt, errcnt_m);
`endif
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %0d err %0d, required none", sym_data, sym_err);
        end else begin
          mon_r = exp_q.pop_front();
          check("sym_data", sym_data, mon_r.data);
          check("sym_err", sym_err, mon_r.err);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    clk16     = 1'b0;
    state_in  = 1'b0;
    Din       = 1'b1;
    sym_ready = 1'b0;
    #2;
    do_reset();

    // Single pulse at tick 5, pulse on the commit tick, empty, multi (ticks 1 and 5).
    align();
    run_symbol(4'b0100, 1'b1, TPS);
    run_symbol(4'b1000, 1'b1, TPS);
    run_symbol(4'b0000, 1'b1, TPS);
    run_symbol(4'b0101, 1'b1, TPS);
    run_symbol(4'b0001, 1'b1, TPS);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);

    // Overrun: hold ready low for two symbols, then drop state_in, then drain.
    align();
    run_symbol(4'b0100, 1'b0, TPS);
    run_symbol(4'b0010, 1'b0, TPS);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);

    // Reset at tick 4 with a result pending, then a clean symbol.
    align();
    run_symbol(4'b0010, 1'b0, TPS);
    run_symbol(4'b1000, 1'b0, 4);
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    run_symbol(4'b0010, 1'b1, TPS);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);

    // Random line noise, tick spacing, back-pressure and frame drops.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 2) == 0,
            $urandom_range(0, 199) != 0,
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppm_symbol_decoder.md
# ppm_symbol_decoder

Parametrised pulse-position-modulation symbol decoder for the PPM receive path. It replaces the fixed 2-bit/4-slot decoder, which had no error reporting. The block divides an active frame into symbols of 2^SYM_BITS slots, samples the registered pulse line once per slot on the oversampling strobe, and emits one decoded symbol per symbol period. Each symbol carries an error code, and a valid/ready output holding register feeds the downstream deframer.

## Interface
- SYM_BITS, 2: bits per symbol, legal range 1..4; slots per symbol NSLOT = 2^SYM_BITS.
- SLOT_TICKS, 2: clk16 ticks per slot, must be ≥1.
- SAMPLE_TICK, 1: tick index within a slot at which the pulse is sampled, range 0..SLOT_TICKS-1.

Ports (clock and reset first):
- clk  in  1  single system clock; every register updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clk16  in  1  one-clk-wide oversampling tick enable.
- state_in  in  1  frame active; low holds the symbol timer cleared.
- Din  in  1  PPM line, pulse active low.
- sym_data  out  SYM_BITS  decoded slot index.
- sym_err  out  2  00 = ok, 01 = empty (no pulse), 10 = multi (more than one pulse).
- sym_valid  out  1  output holding register full.
- sym_ready  in  1  downstream accepts.
- ovf  out  1  sticky overrun flag.
- err_cnt  out  8  present only with PPMDEC_ERRCNT_EN.

## Operation
- Input register: din_q <= !Din on every clk; reset value 0.
- A tick is a clk cycle where clk16 && state_in.
- Symbol timer:
  - tick_cnt runs 0..SLOT_TICKS-1 and slot_cnt runs 0..NSLOT-1, both advancing on ticks.
  - slot_cnt increments when tick_cnt wraps.
  - Both wrap to 0 after the last tick of a symbol, so consecutive symbols follow with no gap.
- Sample: on a tick with tick_cnt == SAMPLE_TICK and din_q == 1, record a hit for slot_cnt.
  - First hit: store pos = slot_cnt and set found.
  - Further hits in the same symbol: set multi; pos is kept.
- Commit: on the tick with slot_cnt == NSLOT-1 and tick_cnt == SLOT_TICKS-1.
  - The commit includes a sample occurring on that same tick.
  - Result: sym_data = pos, or 0 if nothing was found.
  - Result: sym_err = 10 if multi, else 01 if not found, else 00.
  - found, multi and pos are cleared for the next symbol.
- Output register:
  - A transfer occurs when sym_valid && sym_ready; it clears sym_valid.
  - A commit loads the result and sets sym_valid.
  - Commit and transfer in the same cycle: the new result is loaded and sym_valid stays 1; this is not an overrun.
  - Commit while sym_valid && !sym_ready: the new result is dropped, the held result is unchanged, and ovf is set.
- state_in low:
  - Counters, found, multi and pos are cleared synchronously, and any partial symbol is discarded.
  - ovf is cleared.
  - The output register and sym_valid are unaffected.
- Reset values: sym_data 0, sym_err 00, sym_valid 0, ovf 0, err_cnt 0, and all internal state 0.

## Timing
- Din to din_q: 1 clk. Din must be low in the clk cycle before the sampling tick.
- sym_valid rises on the clk edge following the commit tick, i.e. on the first cycle after the commit.
- A decoded symbol is available once every NSLOT*SLOT_TICKS ticks.
- Throughput: sym_ready may be held high permanently. With ready high, each symbol is consumed in one cycle.
- state_in falling in the same cycle as the commit tick: there is no commit, because a tick requires state_in high.

## Configuration
- PPMDEC_ERRCNT_EN defined:
  - Adds the err_cnt port.
  - err_cnt increments on every commit with sym_err != 00, including dropped (overrun) commits.
  - It saturates at 255 and is cleared only by rst_n.
- PPMDEC_ERRCNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package ppm_dec_pkg contains:
  - typedef enum logic [1:0] ppm_err_t with values ERR_OK, ERR_EMPTY, ERR_MULTI;
  - constant ERRCNT_W = 8.
- Sub-module ppm_slot_timer holds tick_cnt and slot_cnt and outputs sample_en, sym_end and slot_idx. It takes the same parameters minus SYM_BITS-derived widths.
- The top level contains the input register, capture logic, output register and ovf/err_cnt.

## Test plan
All scenarios use the defaults SYM_BITS=2, SLOT_TICKS=2, SAMPLE_TICK=1, giving 8 ticks per symbol with samples at ticks 1, 3, 5, 7.
- Single pulse: state_in high, sym_ready high, Din low only in the cycle before tick 5 → the cycle after tick 7 shows sym_valid=1, sym_data=2, sym_err=00.
- Last-slot pulse on the commit tick: pulse sampled at tick 7 → sym_data=3, sym_err=00.
- No pulse in a symbol → sym_data=0, sym_err=01. With PPMDEC_ERRCNT_EN, err_cnt goes 0→1.
- Pulses sampled at ticks 1 and 5 → sym_data=0, sym_err=10.
- Overrun: sym_ready low for two symbols → the first result is held, the second is dropped, ovf=1. Dropping state_in then clears ovf, while sym_valid stays 1.
- Reset mid-operation: assert rst_n low at tick 4 with a pending output → all outputs return to 0 immediately. After release, the next full symbol decodes correctly from tick 0.
